// File: rtl/md_sequencer.sv
// Multi-cycle unsigned multiply/divide sequencer for the EX stage.
// Borrows the shared ALU one bit per cycle and writes HI/LO on completion.
module md_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             abort,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] m;
    logic             is_div;

    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             take;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic             last;

    assign sh   = {w_hi[WIDTH-2:0], w_lo[WIDTH-1]};
    assign busy = (state != IDLE);
    assign last = (count == CNT_W'(WIDTH - 1));

    // ALU operands: only driven while iterating, parked at zero otherwise
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = 3'b000;
        if (state == RUN) begin
            alu_b = m;
            if (is_div) begin
                alu_a    = sh;
                alu_ctrl = 3'b001;
            end else begin
                alu_a = w_hi;
            end
        end
    end

    // One shift-add or restoring-subtract step from the current ALU result
    always_comb begin
        carry  = 1'b0;
        take   = 1'b0;
        sum    = w_hi;
        nxt_hi = w_hi;
        nxt_lo = w_lo;
        if (is_div) begin
            take   = w_hi[WIDTH-1] | (sh >= m);
            nxt_hi = take ? alu_result : sh;
            nxt_lo = {w_lo[WIDTH-2:0], take};
        end else begin
            if (w_lo[0]) begin
                carry = (alu_result < w_hi);
                sum   = alu_result;
            end
            nxt_hi = {carry, sum[WIDTH-1:1]};
            nxt_lo = {sum[0], w_lo[WIDTH-1:1]};
        end
    end

    // Sequencer FSM; HI/LO and done are registered on the final iteration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            w_hi        <= '0;
            w_lo        <= '0;
            m           <= '0;
            is_div      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                count <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            w_hi        <= '0;
                            w_lo        <= op_div ? rs_val : rt_val;
                            m           <= op_div ? rt_val : rs_val;
                            is_div      <= op_div;
                            count       <= '0;
                            div_by_zero <= 1'b0;
                            state       <= RUN;
                        end
                    end
                    RUN: begin
                        w_hi  <= nxt_hi;
                        w_lo  <= nxt_lo;
                        count <= count + CNT_W'(1);
                        if (last) begin
                            hi          <= nxt_hi;
                            lo          <= nxt_lo;
                            done        <= 1'b1;
                            div_by_zero <= is_div && (m == '0);
                            state       <= DONE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer with a behavioural ALU attached.
// Vector table for results plus hand sequences for start/abort/reset.
module tb_md_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op_div;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        abort;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    md_sequencer #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op_div      (op_div),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .abort       (abort),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    // Shared single-cycle ALU: add or subtract
    assign alu_result = (alu_ctrl == 3'b001) ? (alu_a - alu_b)
                                             : (alu_a + alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edbz;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic kick(input logic op, input logic [31:0] a,
                        input logic [31:0] b);
        start  = 1'b1;
        op_div = op;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done; returns edges after start and busy cycle count
    task automatic wait_done(output int n_done, output int n_busy,
                             output logic [31:0] rhi,
                             output logic [31:0] rlo,
                             output logic rdbz);
        n_done = 0;
        n_busy = busy ? 1 : 0;
        rhi    = '0;
        rlo    = '0;
        rdbz   = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (busy) n_busy++;
            if (done && n_done == 0) begin
                n_done = e;
                rhi    = hi;
                rlo    = lo;
                rdbz   = div_by_zero;
            end
            if (!busy) break;
        end
    endtask

    initial begin
        int          nd;
        int          nb;
        logic [31:0] rhi;
        logic [31:0] rlo;
        logic        rdbz;
        int          seen;

        checks   = 0;
        failures = 0;
        start    = 1'b0;
        op_div   = 1'b0;
        rs_val   = '0;
        rt_val   = '0;
        abort    = 1'b0;
        rst      = 1'b0;

        vecs[0]  = '{1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0};
        vecs[1]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
        vecs[3]  = '{1'b1, 32'h80000000, 32'd3,
                     32'd2, 32'h2AAAAAAA, 1'b0};
        vecs[4]  = '{1'b1, 32'h1234, 32'd0,
                     32'h1234, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{1'b0, 32'h10000, 32'h10000, 32'd1, 32'd0, 1'b0};
        vecs[6]  = '{1'b0, 32'h12345678, 32'd0, 32'd0, 32'd0, 1'b0};
        vecs[7]  = '{1'b1, 32'hFFFFFFFF, 32'd1,
                     32'd0, 32'hFFFFFFFF, 1'b0};
        vecs[8]  = '{1'b1, 32'd5, 32'd10, 32'd5, 32'd0, 1'b0};
        vecs[9]  = '{1'b0, 32'h80000000, 32'd2, 32'd1, 32'd0, 1'b0};
        vecs[10] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'd0, 32'd1, 1'b0};

        #12;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            logic prev_dbz;
            prev_dbz = div_by_zero;
            if (i == 5) check("dbz_hold", {31'd0, prev_dbz}, 32'd1);
            kick(vecs[i].op, vecs[i].rs, vecs[i].rt);
            check($sformatf("v%0d_busy0", i), {31'd0, busy}, 32'd1);
            check($sformatf("v%0d_dbzclr", i), {31'd0, div_by_zero}, 32'd0);
            check($sformatf("v%0d_ctrl", i), {29'd0, alu_ctrl},
                  {31'd0, vecs[i].op});
            wait_done(nd, nb, rhi, rlo, rdbz);
            check($sformatf("v%0d_lat", i), nd, 32);
            check($sformatf("v%0d_busycyc", i), nb, 33);
            check($sformatf("v%0d_hi", i), rhi, vecs[i].ehi);
            check($sformatf("v%0d_lo", i), rlo, vecs[i].elo);
            check($sformatf("v%0d_dbz", i), {31'd0, rdbz},
                  {31'd0, vecs[i].edbz});
            check($sformatf("v%0d_idle_a", i), alu_a, 32'd0);
        end

        // start during RUN is ignored
        kick(1'b0, 32'd7, 32'd6);
        repeat (9) @(posedge clk);
        #1;
        start  = 1'b1;
        op_div = 1'b1;
        rs_val = 32'd1000;
        rt_val = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(nd, nb, rhi, rlo, rdbz);
        check("ign_lat", nd, 22);
        check("ign_hi", rhi, 32'd0);
        check("ign_lo", rlo, 32'd42);

        // abort mid-RUN
        kick(1'b0, 32'd3, 32'd3);
        repeat (15) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("abort_nodone", seen, 0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd42);

        // async reset mid-RUN
        kick(1'b0, 32'd9, 32'd9);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_lo", lo, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_alu_b", alu_b, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("arst_stay", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
